// File: rtl/audio_clk_sequencer.sv
// Codec clock generator (MCLK/BCLK/LRCK) with glitch-free reconfiguration at frame boundaries.
// Outputs registered (ocfg_ready is combinational); one config may be pending, ocfg_ready stays low until it is applied.
module audio_clk_sequencer #(
    parameter int MCLK_HALF_DEFAULT  = 3,
    parameter int BCLK_RATIO_DEFAULT = 1,
    parameter int SLOT_BITS          = 32,
    parameter int LOCK_FRAMES        = 2
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       ienable,
    input  logic       icfg_valid,
    input  logic [7:0] icfg_mclk_half,
    input  logic [3:0] icfg_bclk_ratio,
    output logic       ocfg_ready,
    output logic       omclk,
    output logic       obclk,
    output logic       olrck,
    output logic       obclk_fall_stb,
    output logic       oframe_stb,
    output logic       olocked
);
    localparam int SW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int FW = $clog2(LOCK_FRAMES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_APPLY = 2'd3;

    typedef struct packed {
        logic [7:0] half;
        logic [3:0] ratio;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{half: 8'(MCLK_HALF_DEFAULT), ratio: 4'(BCLK_RATIO_DEFAULT)};
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_BITS - 1);
    localparam logic [FW-1:0] LOCK_LAST = FW'(LOCK_FRAMES - 1);

    logic [1:0]    state;
    logic [1:0]    nxt;
    cfg_t          act_cfg;
    cfg_t          pend_cfg;
    cfg_t          in_cfg;
    logic          pend_vld;
    logic          cfg_acc;
    logic          running;
    logic [7:0]    mcnt;
    logic [3:0]    bcnt;
    logic [SW-1:0] scnt;
    logic [FW-1:0] fcnt;
    logic          mclk_tick;
    logic          mclk_fall;
    logic          bclk_tick;
    logic          bclk_fall;
    logic          lrck_tick;
    logic          lrck_fall;

    assign ocfg_ready = ((state == ST_IDLE) || (state == ST_RUN)) && !pend_vld;
    assign cfg_acc    = icfg_valid && ocfg_ready;

    // Zero ratios saturate to 1 on capture so the active config is never zero.
    assign in_cfg.half  = (icfg_mclk_half == 8'd0) ? 8'd1 : icfg_mclk_half;
    assign in_cfg.ratio = (icfg_bclk_ratio == 4'd0) ? 4'd1 : icfg_bclk_ratio;

    assign running   = (state == ST_RUN) || (state == ST_DRAIN);
    assign mclk_tick = running && (mcnt == act_cfg.half - 8'd1);
    assign mclk_fall = mclk_tick && omclk;
    assign bclk_tick = mclk_fall && (bcnt == act_cfg.ratio - 4'd1);
    assign bclk_fall = bclk_tick && obclk;
    assign lrck_tick = bclk_fall && (scnt == SLOT_LAST);
    assign lrck_fall = lrck_tick && olrck;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (pend_vld || ienable) nxt = ST_APPLY;
            ST_APPLY: nxt = ienable ? ST_RUN : ST_IDLE;
            ST_RUN:   if (cfg_acc || !ienable) nxt = ST_DRAIN;
            ST_DRAIN: if (lrck_fall) nxt = pend_vld ? ST_APPLY : ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state    <= ST_IDLE;
            pend_vld <= 1'b0;
            pend_cfg <= CFG_DEFAULT;
            act_cfg  <= CFG_DEFAULT;
        end else begin
            state <= nxt;
            if (cfg_acc) begin
                pend_vld <= 1'b1;
                pend_cfg <= in_cfg;
            end else if (state == ST_APPLY) begin
                pend_vld <= 1'b0;
                if (pend_vld) act_cfg <= pend_cfg;
            end
        end
    end

    // Every LRCK fall coincides with BCLK and MCLK falls with all counters wrapping,
    // so the drain exit lands on a cycle where all clocks are already low.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            mcnt           <= '0;
            bcnt           <= '0;
            scnt           <= '0;
            omclk          <= 1'b0;
            obclk          <= 1'b0;
            olrck          <= 1'b0;
            obclk_fall_stb <= 1'b0;
            oframe_stb     <= 1'b0;
        end else if (!running) begin
            mcnt           <= '0;
            bcnt           <= '0;
            scnt           <= '0;
            omclk          <= 1'b0;
            obclk          <= 1'b0;
            olrck          <= 1'b0;
            obclk_fall_stb <= 1'b0;
            oframe_stb     <= 1'b0;
        end else begin
            obclk_fall_stb <= bclk_fall;
            oframe_stb     <= lrck_fall;
            if (mclk_tick) begin
                mcnt  <= '0;
                omclk <= ~omclk;
            end else begin
                mcnt <= mcnt + 8'd1;
            end
            if (mclk_fall) begin
                if (bclk_tick) begin
                    bcnt  <= '0;
                    obclk <= ~obclk;
                end else begin
                    bcnt <= bcnt + 4'd1;
                end
            end
            if (bclk_fall) begin
                if (lrck_tick) begin
                    scnt  <= '0;
                    olrck <= ~olrck;
                end else begin
                    scnt <= scnt + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            fcnt    <= '0;
            olocked <= 1'b0;
        end else if ((state == ST_RUN) && (nxt == ST_RUN)) begin
            if (lrck_fall && !olocked) begin
                fcnt <= fcnt + FW'(1);
                if (fcnt == LOCK_LAST) olocked <= 1'b1;
            end
        end else begin
            fcnt    <= '0;
            olocked <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_clk_sequencer.sv
// Scoreboard bench: a timestamp-based reference predicts every output per cycle.
module tb_audio_clk_sequencer;
    localparam int SLOT  = 32;
    localparam int LOCKF = 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_APPLY = 3;

    logic       iclk = 1'b0;
    logic       irst_n = 1'b1;
    logic       ienable = 1'b0;
    logic       icfg_valid = 1'b0;
    logic [7:0] icfg_mclk_half = 8'd0;
    logic [3:0] icfg_bclk_ratio = 4'd0;
    logic       ocfg_ready;
    logic       omclk;
    logic       obclk;
    logic       olrck;
    logic       obclk_fall_stb;
    logic       oframe_stb;
    logic       olocked;
    logic [6:0] dut_vec;

    audio_clk_sequencer #(
        .MCLK_HALF_DEFAULT (3),
        .BCLK_RATIO_DEFAULT(1),
        .SLOT_BITS         (SLOT),
        .LOCK_FRAMES       (LOCKF)
    ) dut (
        .iclk           (iclk),
        .irst_n         (irst_n),
        .ienable        (ienable),
        .icfg_valid     (icfg_valid),
        .icfg_mclk_half (icfg_mclk_half),
        .icfg_bclk_ratio(icfg_bclk_ratio),
        .ocfg_ready     (ocfg_ready),
        .omclk          (omclk),
        .obclk          (obclk),
        .olrck          (olrck),
        .obclk_fall_stb (obclk_fall_stb),
        .oframe_stb     (oframe_stb),
        .olocked        (olocked)
    );

    assign dut_vec = {ocfg_ready, omclk, obclk, olrck, obclk_fall_stb, oframe_stb, olocked};

    always #10 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] v;
        string      tag;
    } exp_t;

    exp_t  sbq[$];
    exp_t  mon_e;
    int    n_chk = 0;
    int    n_fail = 0;
    string phase = "reset";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Vector order: {ready, mclk, bclk, lrck, bclk_fall_stb, frame_stb, locked}
    always @(negedge iclk) begin
        if (sbq.size() > 0 && sbq[0].c == cyc) begin
            mon_e = sbq.pop_front();
            chk($sformatf("%s@%0d", mon_e.tag, mon_e.c), {25'd0, dut_vec}, {25'd0, mon_e.v});
        end
    end

    // Reference state: k counts cycles since the first RUN cycle of the current run.
    int ms, ph, pr, ah, ar, k;
    bit mp;

    task automatic model_reset();
        ms = M_IDLE;
        mp = 1'b0;
        ph = 3;
        pr = 1;
        ah = 3;
        ar = 1;
        k  = 0;
    endtask

    task automatic model_step();
        int         ns, nk, fr;
        bit         acc, nrun, nlock;
        logic [6:0] v;
        exp_t       e;
        acc   = icfg_valid && (ms == M_IDLE || ms == M_RUN) && !mp;
        fr    = 2 * SLOT * 4 * ah * ar;
        ns    = ms;
        nk    = 0;
        nrun  = 1'b0;
        nlock = 1'b0;
        case (ms)
            M_IDLE:  if (mp || ienable) ns = M_APPLY;
            M_APPLY: ns = ienable ? M_RUN : M_IDLE;
            M_RUN: begin
                nk    = k + 1;
                nrun  = 1'b1;
                ns    = (acc || !ienable) ? M_DRAIN : M_RUN;
                nlock = (ns == M_RUN) && (nk >= LOCKF * fr);
            end
            default: begin
                nk   = k + 1;
                nrun = 1'b1;
                if (nk % fr == 0) ns = mp ? M_APPLY : M_IDLE;
            end
        endcase
        v = 7'd0;
        if (nrun) begin
            v[5] = ((nk / ah) % 2) == 1;
            v[4] = ((nk / (2 * ah * ar)) % 2) == 1;
            v[3] = ((nk / (fr / 2)) % 2) == 1;
            v[2] = (nk % (4 * ah * ar)) == 0;
            v[1] = (nk % fr) == 0;
            v[0] = nlock;
        end
        if (ms == M_APPLY && mp) begin
            ah = ph;
            ar = pr;
            mp = 1'b0;
        end
        if (acc) begin
            mp = 1'b1;
            ph = (icfg_mclk_half == 8'd0) ? 1 : int'(icfg_mclk_half);
            pr = (icfg_bclk_ratio == 4'd0) ? 1 : int'(icfg_bclk_ratio);
        end
        v[6] = (ns == M_IDLE || ns == M_RUN) && !mp;
        ms = ns;
        k  = nk;
        e.c   = cyc + 1;
        e.v   = v;
        e.tag = phase;
        sbq.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            model_step();
            @(posedge iclk);
            #1;
        end
    endtask

    initial begin
        int w;
        model_reset();
        #1 irst_n = 1'b0;
        #4;
        chk("reset_outs", {25'd0, dut_vec}, 32'h40);
        ienable = 1'b1;
        @(posedge iclk);
        @(posedge iclk);
        #1 irst_n = 1'b1;

        phase = "A_default";
        run(1700);

        phase = "B_cfg11";
        run(100);
        icfg_valid = 1'b1;
        icfg_mclk_half = 8'd1;
        icfg_bclk_ratio = 4'd1;
        run(1);
        icfg_valid = 1'b0;
        run(20);
        ienable = 1'b0;
        run(3);
        ienable = 1'b1;
        run(1000);

        phase = "C_cfg23";
        icfg_valid = 1'b1;
        icfg_mclk_half = 8'd2;
        icfg_bclk_ratio = 4'd3;
        run(1);
        icfg_valid = 1'b0;
        run(600);
        phase = "C_disable";
        ienable = 1'b0;
        run(1700);
        phase = "C_cfg00";
        icfg_valid = 1'b1;
        icfg_mclk_half = 8'd0;
        icfg_bclk_ratio = 4'd0;
        ienable = 1'b1;
        run(1);
        icfg_valid = 1'b0;
        run(700);

        phase = "D_hold";
        icfg_valid = 1'b1;
        icfg_mclk_half = 8'd4;
        icfg_bclk_ratio = 4'd2;
        run(5);
        icfg_mclk_half = 8'd5;
        icfg_bclk_ratio = 4'd1;
        run(400);
        icfg_valid = 1'b0;
        run(2600);

        phase = "E_reset";
        w = 0;
        while (omclk !== 1'b1 && w < 50) begin
            run(1);
            w++;
        end
        chk("E_mclk_high", {31'd0, omclk}, 32'd1);
        #4 irst_n = 1'b0;
        sbq.delete();
        #1;
        chk("E_async_rst", {25'd0, dut_vec}, 32'h40);
        model_reset();
        @(posedge iclk);
        #1;
        @(posedge iclk);
        #1 irst_n = 1'b1;
        phase = "E_restart";
        run(1700);

        @(negedge iclk);
        #1;
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
